// File: rtl/decoder_pkg.sv
// Shared widths and a reference one-hot helper for the 3-to-8 decoder family.
package decoder_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  // One-hot word for a 3-bit select value: bit sel is set, all others clear.
  function automatic logic [OUT_W-1:0] onehot3(input logic [SEL_W-1:0] sel);
    return OUT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/decoder_2_to_4.sv
// 2-to-4 one-hot decoder with active-high enable. A low enable forces zero,
// so an unknown select cannot propagate to the output.
module decoder_2_to_4 (
  input  logic       a,
  input  logic       b,
  input  logic       en,
  output logic [3:0] d
);

  // Decode {a, b} (a is the MSB) into a one-hot nibble, gated by en.
  always_comb begin
    d = 4'b0000;
    if (en) begin
      case ({a, b})
        2'b00:   d = 4'b0001;
        2'b01:   d = 4'b0010;
        2'b10:   d = 4'b0100;
        2'b11:   d = 4'b1000;
        default: d = 4'b0000;
      endcase
    end else begin
      d = 4'b0000;
    end
  end

endmodule

// File: rtl/decoder_3_to_8.sv
// Registered 3-to-8 one-hot decoder built from two 2-to-4 halves.
// x picks the half, {y, z} picks the bit within it. Optional output
// inversion (ACTIVE_LOW) and optional output register (OUT_REG).
module decoder_3_to_8
  import decoder_pkg::*;
#(
  parameter bit OUT_REG    = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  input  logic             en,
  output logic [OUT_W-1:0] w
);

  // Value w takes while disabled or in reset.
  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic             en_hi;
  logic             en_lo;
  logic [3:0]       dec_hi;
  logic [3:0]       dec_lo;
  logic [OUT_W-1:0] w_d;

  // Enable split: a low en forces both halves off even if x is unknown.
  assign en_hi = en & x;
  assign en_lo = en & ~x;

  decoder_2_to_4 u_dec_hi (
    .a  (y),
    .b  (z),
    .en (en_hi),
    .d  (dec_hi)
  );

  decoder_2_to_4 u_dec_lo (
    .a  (y),
    .b  (z),
    .en (en_lo),
    .d  (dec_lo)
  );

  // Assemble the full word and apply the output polarity.
  always_comb begin
    w_d = {dec_hi, dec_lo};
    if (ACTIVE_LOW) begin
      w_d = ~{dec_hi, dec_lo};
    end else begin
      w_d = {dec_hi, dec_lo};
    end
  end

  generate
    if (OUT_REG) begin : g_reg
      logic [OUT_W-1:0] w_q;

      // Output register: reset drives the inactive value immediately.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          w_q <= INACTIVE;
        end else begin
          w_q <= w_d;
        end
      end

      assign w = w_q;
    end else begin : g_comb
      assign w = w_d;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_3_to_8.sv
// Scoreboard bench for decoder_3_to_8: default and ACTIVE_LOW instances share
// stimulus, a combinational (OUT_REG = 0) instance is checked directly.
`timescale 1ns/1ps
module tb_decoder_3_to_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       x, y, z, en;
  logic [7:0] w, wl;
  logic       cx, cy, cz, cen, crst;
  logic [7:0] wc;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  typedef struct {
    logic [7:0] e;
    logic [7:0] el;
    int         due;
  } exp_t;

  exp_t q[$];
  exp_t item;

  always #5 clk = ~clk;

  decoder_3_to_8 #(.OUT_REG(1'b1), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .en(en), .w(w)
  );

  decoder_3_to_8 #(.OUT_REG(1'b1), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .en(en), .w(wl)
  );

  decoder_3_to_8 #(.OUT_REG(1'b0), .ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .rst(crst), .x(cx), .y(cy), .z(cz), .en(cen), .w(wc)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge counter used to time when a queued expectation becomes due.
  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: compare registered outputs against due scoreboard entries.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cycle) begin
      item = q.pop_front();
      check("w", w, item.e);
      check("w_active_low", wl, item.el);
    end
  end

  // Apply one vector shortly after an edge; it is captured on the next edge.
  task automatic step(input logic [2:0] sel, input logic e, input logic [7:0] exp, input logic [7:0] expl);
    exp_t it;
    @(posedge clk);
    #2;
    {x, y, z} = sel;
    en = e;
    it.e = exp; it.el = expl; it.due = cycle + 1;
    q.push_back(it);
  endtask

  // Wait (bounded) until the monitor has consumed every expectation.
  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
      q.delete();
    end
  endtask

  logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    exp_t it;
    rst = 1'b1; x = 1'b0; y = 1'b0; z = 1'b0; en = 1'b0;
    crst = 1'b0; cx = 1'b0; cy = 1'b0; cz = 1'b0; cen = 1'b0;
    #1;
    check("reset_w", w, 8'h00);
    check("reset_w_active_low", wl, 8'hFF);
    #11 rst = 1'b0;

    // Full sweep, one select per cycle.
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 1'b1, sweep_exp[i], ~sweep_exp[i]);
    end
    drain();

    // Enable toggle, select and enable changing together.
    step(3'b000, 1'b0, 8'h00, 8'hFF);
    step(3'b000, 1'b1, 8'h01, 8'hFE);
    step(3'b111, 1'b0, 8'h00, 8'hFF);
    drain();

    // Disabled with unknown select must give the clean inactive value.
    @(posedge clk); #2;
    x = 1'bx; y = 1'bx; z = 1'bx; en = 1'b0;
    it.e = 8'h00; it.el = 8'hFF; it.due = cycle + 1;
    q.push_back(it);
    drain();

    // Active-low specific vectors.
    step(3'b110, 1'b1, 8'h40, 8'hBF);
    step(3'b110, 1'b0, 8'h00, 8'hFF);
    drain();

    // Reset mid-operation: output clears without an edge and holds.
    step(3'b101, 1'b1, 8'h20, 8'hDF);
    drain();
    #2 rst = 1'b1;
    #1;
    check("rst_async_w", w, 8'h00);
    check("rst_async_w_active_low", wl, 8'hFF);
    @(posedge clk); #1;
    check("rst_hold_w", w, 8'h00);
    check("rst_hold_w_active_low", wl, 8'hFF);
    {x, y, z} = 3'b011; en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    it.e = 8'h08; it.el = 8'hF7; it.due = cycle + 1;
    q.push_back(it);
    drain();

    // Combinational instance: zero latency, reset ignored.
    @(posedge clk); #1;
    {cx, cy, cz} = 3'b010; cen = 1'b1;
    #1 check("comb_sel2", wc, 8'h04);
    {cx, cy, cz} = 3'b100;
    #1 check("comb_sel4", wc, 8'h10);
    crst = 1'b1;
    #1 check("comb_rst_ignored", wc, 8'h10);
    cen = 1'b0;
    #1 check("comb_disabled", wc, 8'h00);
    crst = 1'b0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_3_to_8.md
# decoder_3_to_8

Registered 3-to-8 one-hot decoder with active-high enable. It converts the 3-bit select {x, y, z} into an 8-bit one-hot word `w`, with `x` as the MSB. A low enable forces all outputs inactive. It is a general-purpose select/enable generator and sits between control logic and the blocks it selects (chip selects, write strobes, mux enables).

## Interface
Parameters:
- `OUT_REG`, default 1: 1 registers `w` on `clk`; 0 makes `w` a purely combinational function of the inputs (`clk`/`rst` unused).
- `ACTIVE_LOW`, default 0: 0 means the selected bit is 1 and all others 0; 1 inverts all eight output bits.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `x`  input  1  select bit 2 (MSB).
- `y`  input  1  select bit 1.
- `z`  input  1  select bit 0 (LSB).
- `en`  input  1  decode enable, active-high.
- `w`  output  8  decoded word; `w[i]` corresponds to select value i.

## Operation
- Select value: sel = {x, y, z}, range 0..7.
- Decode, with ACTIVE_LOW = 0:
  - en = 1: w = 8'b1 << sel. Exactly one bit is high: 000→w[0], 001→w[1], 010→w[2], 011→w[3], 100→w[4], 101→w[5], 110→w[6], 111→w[7].
  - en = 0: w = 8'h00, regardless of x/y/z, including when x/y/z are unknown or undriven.
- ACTIVE_LOW = 1: the output is the bitwise inverse of the above. Disabled gives 8'hFF; selected bit is 0.
- Inactive value: the value `w` takes when disabled (8'h00, or 8'hFF when ACTIVE_LOW = 1).
- Unknown select with en = 1: output content is unspecified. The implementation shall not add X-detection logic.
- With en = 0, the enable gating must dominate, so unknown selects never reach `w`.
- At most one output bit is ever active, in every cycle and in both parameter settings.

## Timing
- OUT_REG = 1:
  - x, y, z and en are sampled on the rising edge of `clk`; `w` updates on that edge.
  - Latency is 1 cycle; throughput is one new decode per cycle.
- `rst` asserted, at any time: `w` goes immediately, without a clock edge, to the inactive value. It holds that value while `rst` is high.
- `rst` deasserted: the first rising edge after deassertion loads the decode of the inputs present at that edge.
- Reset mid-operation: the pending decode is discarded; no stale one-hot value appears after reset.
- OUT_REG = 0: `w` follows the inputs combinationally with zero latency, and reset has no effect.
- Changing select and en in the same cycle: the registered result reflects both new values together. No intermediate code appears on `w`.

## Structure
- Shared package `decoder_pkg`:
  - `SEL_W` = 3 and `OUT_W` = 8.
  - `function onehot3(sel)` returning the 8-bit one-hot word.
- Sub-module `decoder_2_to_4` (inputs a, b, en; 4-bit one-hot output):
  - Instantiated twice.
  - The upper instance is enabled by en & x and drives w[7:4].
  - The lower instance is enabled by en & ~x and drives w[3:0].
- The top level contains the enable split, the optional polarity inversion, and the optional output register with async reset.

## Test plan
- Reset: assert `rst` mid-cycle with en = 1, sel = 101. `w` goes to 8'h00 immediately, before the next edge. After release, the first edge with en = 1, sel = 011 gives w = 8'h08.
- Disable with unknown select: x/y/z = X, en = 0, clocked. Required w = 8'h00 (never X).
- Full sweep: en = 1, sel = 000..111, one value per cycle. Required w = 01, 02, 04, 08, 10, 20, 40, 80, each appearing one cycle after it is applied.
- Enable toggle: en = 0, sel = 000 → w = 8'h00. Then en = 1, sel = 000 → w = 8'h01 on the next edge. Then en = 0, sel = 111 → w = 8'h00 on the following edge.
- ACTIVE_LOW = 1: en = 1, sel = 110 → w = 8'hBF. en = 0 → w = 8'hFF. During reset → w = 8'hFF.
- OUT_REG = 0: a sel change from 010 to 100 with en = 1 moves `w` from 8'h04 to 8'h10 with no clock edge. Asserting `rst` has no effect.
